// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixed sequences into {brk,ext,code} events and queues them.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated make events of the key currently held.
module ps2_key_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [9:0] ev_data,
  output logic [7:0] press_cnt,
  output logic       overflow,
  input  logic       ovf_clr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_ev_t;

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          emit;
  key_ev_t       ev_new;
  logic          keep;

  logic          is_e0, is_f0;
  assign is_e0  = (byte_data == 8'hE0);
  assign is_f0  = (byte_data == 8'hF0);
  assign to_hit = (state != IDLE) && !byte_valid && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    emit        = 1'b0;
    ev_new      = '0;
    ev_new.code = byte_data;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (is_e0)      state_nxt = EXT;
          else if (is_f0) state_nxt = BRK;
          else            emit = 1'b1;
        end
        EXT: begin
          if (is_f0)      state_nxt = EXT_BRK;
          else if (!is_e0) begin
            emit       = 1'b1;
            ev_new.ext = 1'b1;
            state_nxt  = IDLE;
          end
        end
        BRK: begin
          if (!(is_e0 || is_f0)) begin
            emit       = 1'b1;
            ev_new.brk = 1'b1;
            state_nxt  = IDLE;
          end
        end
        default: begin
          if (!(is_e0 || is_f0)) begin
            emit       = 1'b1;
            ev_new.brk = 1'b1;
            ev_new.ext = 1'b1;
            state_nxt  = IDLE;
          end
        end
      endcase
    end else if (to_hit) begin
      state_nxt = IDLE;
    end
  end

  // Restarts on every byte so a slow but live sequence is never cut short.
  always_ff @(posedge clk) begin
    if (reset || byte_valid || state_nxt == IDLE) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + 1'b1;
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held;
  logic       held_vld;
  logic       held_hit;
  assign held_hit = (held == {ev_new.ext, ev_new.code});
  assign keep     = ev_new.brk || !(held_vld && held_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= '0;
      held_vld <= 1'b0;
    end else if (emit && !ev_new.brk && keep) begin
      held     <= {ev_new.ext, ev_new.code};
      held_vld <= 1'b1;
    end else if (emit && ev_new.brk && held_hit) begin
      held_vld <= 1'b0;
    end
  end
`else
  assign keep = 1'b1;
`endif

  key_ev_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, wr_req, push, ovf_set;

  assign full     = (count == (AW+1)'(DEPTH));
  assign ev_valid = (count != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
  assign pop      = ev_valid && ev_ready;
  assign wr_req   = emit && keep;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign push     = wr_req && (!full || pop);
  assign ovf_set  = wr_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      press_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !ev_new.brk) press_cnt <= press_cnt + 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with an expected-event queue; honours PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_key_ctrl;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, byte_valid, ev_ready, ovf_clr;
  logic [7:0] byte_data;
  logic       ev_valid, overflow;
  logic [9:0] ev_data;
  logic [7:0] press_cnt;

  ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .press_cnt(press_cnt), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  logic [9:0] q[$];
  int         total = 0;
  int         passed = 0;
  int         exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic expect_ev(input bit brk, input bit ext, input logic [7:0] code);
    q.push_back({brk, ext, code});
    if (!brk) exp_cnt++;
  endtask

  // Caller is at a negedge; the byte is sampled on the next posedge.
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
    exp_cnt = 0;
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    while (q.size() > 0) begin
      int t = 0;
      while (!ev_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!ev_valid) begin
        chk("ev_valid_wait", 32'(ev_valid), 32'd1);
        q.delete();
      end else begin
        chk("ev_data", 32'(ev_data), 32'(q.pop_front()));
        @(negedge clk);
      end
    end
    ev_ready = 1'b0;
    chk("empty_after_drain", 32'(ev_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; ev_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_data", 32'(ev_data), 32'd0);
    chk("rst_press_cnt", 32'(press_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Repeated make then break, bytes back to back
    send(8'h1C); expect_ev(0, 0, 8'h1C);
    chk("latency_ev_valid", 32'(ev_valid), 32'd1);
    send(8'h1C); if (!FILT) expect_ev(0, 0, 8'h1C);
    send(8'hF0);
    send(8'h1C); expect_ev(1, 0, 8'h1C);
    chk("cnt_repeat", 32'(press_cnt), 32'(exp_cnt));
    drain();

    // Extended make and extended break
    send(8'hE0); send(8'h75); expect_ev(0, 1, 8'h75);
    send(8'hE0); send(8'hF0); send(8'h75); expect_ev(1, 1, 8'h75);
    chk("cnt_ext", 32'(press_cnt), 32'(exp_cnt));
    drain();

    // Prefix abandoned after the timeout; a short gap keeps it alive
    send(8'hE0);
    repeat (TIMEOUT + 4) @(negedge clk);
    send(8'h1C); expect_ev(0, 0, 8'h1C);
    send(8'hE0);
    repeat (5) @(negedge clk);
    send(8'h6B); expect_ev(0, 1, 8'h6B);
    drain();
    chk("cnt_timeout", 32'(press_cnt), 32'(exp_cnt));

    // Overflow with DEPTH+1 makes and no consumer
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send(8'(i));
      if (i <= DEPTH) expect_ev(0, 0, 8'(i));
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(press_cnt), 32'(DEPTH));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    send(8'h0B);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("drop_no_count", 32'(press_cnt), 32'(DEPTH));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    // Full FIFO, pop and push in the same cycle
    ev_ready = 1'b1;
    chk("head_before_pop", 32'(ev_data), 32'(q.pop_front()));
    send(8'h0A); expect_ev(0, 0, 8'h0A);
    ev_ready = 1'b0;
    chk("full_popush_ovf", 32'(overflow), 32'd0);
    chk("full_popush_cnt", 32'(press_cnt), 32'(exp_cnt));
    drain();

    // Reset in the middle of a break sequence
    send(8'hF0);
    do_reset();
    chk("midrst_ev_valid", 32'(ev_valid), 32'd0);
    chk("midrst_press_cnt", 32'(press_cnt), 32'd0);
    send(8'h1C); expect_ev(0, 0, 8'h1C);
    chk("midrst_make_cnt", 32'(press_cnt), 32'(exp_cnt));
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
